prog_loader: RTL

Byte-stream program loader for the microcontroller's program memory. It accepts a length-prefixed image over a valid/ready byte interface and writes one instruction word per handshake pair into program memory. It holds the CPU in reset until the full image is written. It sits between the host/boot byte source and the MicroController's program-memory write port, and drives the CPU reset.

---
 rtl/prog_loader_pkg.sv | 26 ++
 rtl/prog_loader.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the byte-stream program loader.
package prog_loader_pkg;

  // Width of the big-endian word-count header and of each image word.
  localparam int LEN_W  = 16;
  // Width of one transferred image byte.
  localparam int BYTE_W = 8;

  // Loader sequencing states.
  typedef enum logic [2:0] {
    LEN_HI = 3'd0,
    LEN_LO = 3'd1,
    W_HI   = 3'd2,
    W_LO   = 3'd3,
    FLUSH  = 3'd4,
    DONE   = 3'd5,
    ERR    = 3'd6
  } state_t;

  // True when every bit above the instruction field of an image word is zero.
  function automatic logic hi_bits_clear(input logic [LEN_W-1:0] word,
                                         input int unsigned      instr_w);
    return (word >> instr_w) == {LEN_W{1'b0}};
  endfunction

endpackage

// File: rtl/prog_loader.sv
// Program loader: takes a length-prefixed big-endian image over a valid/ready
// byte stream, writes one instruction per byte pair into program memory and
// keeps the CPU in reset until the whole image has landed.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int INSTR_W = 12,
  parameter int DEPTH   = 256,
  parameter int ADDR_W  = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [BYTE_W-1:0]  in_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               reload,
  output logic               pm_we,
  output logic [ADDR_W-1:0]  pm_addr,
  output logic [INSTR_W-1:0] pm_wdata,
  output logic               cpu_rst,
  output logic               done,
  output logic               err
);

  state_t             state_r;
  state_t             state_s;
  logic [LEN_W-1:0]   cnt_r;
  logic [BYTE_W-1:0]  word_hi_r;
  logic               xfer_s;
  logic               wr_s;
  logic               restart_s;
  logic [LEN_W-1:0]   len_s;
  logic [LEN_W-1:0]   word_s;

  // Moore decode: a byte is only accepted in the four header/word states.
  assign in_ready = (state_r == LEN_HI) || (state_r == LEN_LO) ||
                    (state_r == W_HI)   || (state_r == W_LO);
  assign xfer_s   = in_valid && in_ready;
  assign len_s    = {cnt_r[LEN_W-1:BYTE_W], in_data};
  assign word_s   = {word_hi_r, in_data};

  // State register; reset always returns to the start of a fresh image.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= LEN_HI;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode plus write and restart strobes for the datapath.
  always_comb begin
    state_s   = state_r;
    wr_s      = 1'b0;
    restart_s = 1'b0;
    case (state_r)
      LEN_HI: begin
        if (xfer_s) state_s = LEN_LO;
        else        state_s = state_r;
      end
      LEN_LO: begin
        if (xfer_s) begin
          // Length check is done one bit wider so N = 65535 cannot alias.
          if (len_s == 16'd0)                      state_s = FLUSH;
          else if ({1'b0, len_s} > 17'(DEPTH))     state_s = ERR;
          else                                     state_s = W_HI;
        end else begin
          state_s = state_r;
        end
      end
      W_HI: begin
        if (xfer_s) state_s = W_LO;
        else        state_s = state_r;
      end
      W_LO: begin
        if (xfer_s) begin
          if (!hi_bits_clear(word_s, INSTR_W)) begin
            state_s = ERR;
          end else begin
            wr_s = 1'b1;
            if (cnt_r == 16'd1) state_s = FLUSH;
            else                state_s = W_HI;
          end
        end else begin
          state_s = state_r;
        end
      end
      FLUSH: begin
        // Separates the last write from CPU release by one cycle.
        state_s = DONE;
      end
      DONE, ERR: begin
        if (reload) begin
          state_s   = LEN_HI;
          restart_s = 1'b1;
        end else begin
          state_s = state_r;
        end
      end
      default: begin
        state_s = LEN_HI;
      end
    endcase
  end

  // Datapath: count/word capture, write port and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r     <= 16'd0;
      word_hi_r <= 8'd0;
      pm_we     <= 1'b0;
      pm_addr   <= '0;
      pm_wdata  <= '0;
      cpu_rst   <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      pm_we <= wr_s;
      if (wr_s) begin
        pm_wdata <= word_s[INSTR_W-1:0];
      end
      if (state_r == LEN_HI && xfer_s) begin
        cnt_r <= {in_data, cnt_r[BYTE_W-1:0]};
      end else if (state_r == LEN_LO && xfer_s) begin
        cnt_r <= len_s;
      end else if (wr_s) begin
        cnt_r <= cnt_r - 16'd1;
      end
      if (state_r == W_HI && xfer_s) begin
        word_hi_r <= in_data;
      end
      // Address advances after each write; it holds at the top entry so a
      // full-depth image leaves it at DEPTH-1 rather than wrapping.
      if (restart_s) begin
        pm_addr <= '0;
      end else if (pm_we && (pm_addr != ADDR_W'(DEPTH - 1))) begin
        pm_addr <= pm_addr + ADDR_W'(1);
      end
      done    <= (state_s == DONE);
      err     <= (state_s == ERR);
      cpu_rst <= (state_s != DONE);
    end
  end

endmodule
